// File: rtl/recoded_float32_to_recoded_float64_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module  : recoded_float32_to_recoded_float64_pipe_pkg
// Brief   : Shared FPU constants and classification helper for recoded floats
// Revision: 1.0 - initial release
// ============================================================================
package recoded_float32_to_recoded_float64_pipe_pkg;

   localparam logic [11:0] F32_TO_F64_EXP_DELTA = 12'h700;

   localparam logic [2:0] EXP_ZERO = 3'b000;
   localparam logic [2:0] EXP_INF  = 3'b110;
   localparam logic [2:0] EXP_NAN  = 3'b111;

   localparam int FLAG_INVALID     = 4;
   localparam int FLAG_DIV_BY_ZERO = 3;
   localparam int FLAG_OVERFLOW    = 2;
   localparam int FLAG_UNDERFLOW   = 1;
   localparam int FLAG_INEXACT     = 0;

   typedef enum logic [1:0] {
      CLS_FINITE = 2'd0,
      CLS_ZERO   = 2'd1,
      CLS_INF    = 2'd2,
      CLS_NAN    = 2'd3
   } fp_class_t;

   // Recoded subnormals are already normalised, so only the top three exponent bits matter.
   function automatic fp_class_t classify_f32(input logic [8:0] exp32);
      fp_class_t w_cls;
      case (exp32[8:6])
         EXP_ZERO: w_cls = CLS_ZERO;
         EXP_INF:  w_cls = CLS_INF;
         EXP_NAN:  w_cls = CLS_NAN;
         default:  w_cls = CLS_FINITE;
      endcase
      return w_cls;
   endfunction

endpackage
`default_nettype wire

// File: rtl/recoded_float32_to_recoded_float64_pipe_if.sv
`default_nettype none
// ============================================================================
// Module  : recoded_float32_to_recoded_float64_pipe_if
// Brief   : Operand/result valid-ready bus and flag signals of the f32->f64 pipe
// Revision: 1.0 - initial release
// ============================================================================
interface recoded_float32_to_recoded_float64_pipe_if;
   logic        in_valid;
   logic        in_ready;
   logic [32:0] in;
   logic        out_valid;
   logic        out_ready;
   logic [64:0] out;
   logic [4:0]  out_flags;
   logic [4:0]  accrued_flags;
   logic        clear_flags;

   modport master (
      output in_valid, in, out_ready, clear_flags,
      input  in_ready, out_valid, out, out_flags, accrued_flags
   );

   modport slave (
      input  in_valid, in, out_ready, clear_flags,
      output in_ready, out_valid, out, out_flags, accrued_flags
   );
endinterface
`default_nettype wire

// File: rtl/recoded_float32_to_recoded_float64_pipe_core.sv
`default_nettype none
// ============================================================================
// Module  : recoded_f32_to_f64_core
// Brief   : Combinational exact widening of a recoded f32 to a recoded f64
// Revision: 1.0 - initial release
// ============================================================================
module recoded_f32_to_f64_core
   import recoded_float32_to_recoded_float64_pipe_pkg::*;
(
   input  logic [32:0] i_op,
   input  fp_class_t   i_cls,
   output logic [64:0] o_res,
   output logic [4:0]  o_flags
);

   always_comb begin
      o_res     = '0;
      o_flags   = '0;
      o_res[64] = i_op[32];
      case (i_cls)
         CLS_ZERO, CLS_INF: begin
            o_res[63:52] = {i_op[31:29], 9'b0};
         end
         // Quiet the NaN on the way out; a signaling input raises invalid.
         CLS_NAN: begin
            o_res[63:52]          = {EXP_NAN, 9'b0};
            o_res[51:0]           = {1'b1, i_op[21:0], 29'b0};
            o_flags[FLAG_INVALID] = ~i_op[22];
         end
         default: begin
            o_res[63:52] = {3'b000, i_op[31:23]} + F32_TO_F64_EXP_DELTA;
            o_res[51:0]  = {i_op[22:0], 29'b0};
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/recoded_float32_to_recoded_float64_pipe.sv
`default_nettype none
// ============================================================================
// Module  : recoded_float32_to_recoded_float64_pipe
// Brief   : Two-stage valid/ready pipe around the recoded f32->f64 widening core
// Revision: 1.0 - initial release
// ============================================================================
module recoded_float32_to_recoded_float64_pipe
   import recoded_float32_to_recoded_float64_pipe_pkg::*;
#(
   parameter int DEPTH_STAGES = 2
)
(
   input  logic clk,
   input  logic reset,
   recoded_float32_to_recoded_float64_pipe_if.slave bus
);

   if (DEPTH_STAGES != 2) begin : g_depth_check
      $error("recoded_float32_to_recoded_float64_pipe supports only DEPTH_STAGES == 2");
   end

   logic        r_s1_valid;
   logic [32:0] r_s1_op;
   fp_class_t   r_s1_cls;
   logic        r_s2_valid;
   logic [64:0] r_s2_res;
   logic [4:0]  r_s2_flags;
   logic [4:0]  r_accrued;

   logic        w_s2_load;
   logic        w_s1_load;
   logic        w_consume;
   logic [64:0] w_core_res;
   logic [4:0]  w_core_flags;

   assign w_s2_load = !r_s2_valid || bus.out_ready;
   assign w_s1_load = !r_s1_valid || w_s2_load;
   assign w_consume = r_s2_valid && bus.out_ready;

   recoded_f32_to_f64_core u_core (
      .i_op    (r_s1_op),
      .i_cls   (r_s1_cls),
      .o_res   (w_core_res),
      .o_flags (w_core_flags)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1_valid <= 1'b0;
         r_s1_op    <= '0;
         r_s1_cls   <= CLS_ZERO;
         r_s2_valid <= 1'b0;
         r_s2_res   <= '0;
         r_s2_flags <= '0;
         r_accrued  <= '0;
      end else begin
         if (w_s1_load) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
               r_s1_op  <= bus.in;
               r_s1_cls <= classify_f32(bus.in[31:23]);
            end
         end
         if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
               r_s2_res   <= w_core_res;
               r_s2_flags <= w_core_flags;
            end
         end
         // A consume in the same cycle as a clear keeps its flags.
         r_accrued <= (bus.clear_flags ? 5'b0 : r_accrued) | (w_consume ? r_s2_flags : 5'b0);
      end
   end

   assign bus.in_ready      = !reset && w_s1_load;
   assign bus.out_valid     = r_s2_valid;
   assign bus.out           = r_s2_res;
   assign bus.out_flags     = r_s2_flags;
   assign bus.accrued_flags = r_accrued;

endmodule
`default_nettype wire

// File: tb/tb_recoded_float32_to_recoded_float64_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_recoded_float32_to_recoded_float64_pipe
// Brief   : Directed-vector and scoreboard bench for the f32->f64 widening pipe
// Revision: 1.0 - initial release
// ============================================================================
module tb_recoded_float32_to_recoded_float64_pipe;

   localparam int NV = 11;
   localparam int NR = 10000;

   typedef struct {
      logic [32:0] in;
      logic [64:0] out;
      logic [4:0]  flags;
   } vec_t;

   logic clk;
   logic reset;
   int   n_vec;
   int   n_err;
   vec_t tbl [NV];
   logic [69:0] sb_q [$];

   recoded_float32_to_recoded_float64_pipe_if bus ();

   recoded_float32_to_recoded_float64_pipe #(.DEPTH_STAGES(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp_v);
      n_vec++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp_v);
      end
   endtask

   function automatic logic [32:0] rand_finite();
      logic [8:0]  e;
      logic [22:0] s;
      logic        sg;
      e  = 9'($urandom_range(32'h17F, 32'h040));
      s  = 23'($urandom);
      sg = 1'($urandom);
      return {sg, e, s};
   endfunction

   function automatic logic [69:0] model(input logic [32:0] x);
      logic [11:0] e64;
      e64 = {3'b000, x[31:23]} + 12'h700;
      return {x[32], e64, x[22:0], 29'b0, 5'b0};
   endfunction

   // Drives n_ops operands (table rows or random finite values) and scores results in order.
   task automatic stream(input bit rnd, input int n_ops, input int budget);
      int n_acc, cyc, first_con, last_con;
      logic [69:0] exp_v;
      n_acc = 0; cyc = 0; first_con = -1; last_con = -1;
      sb_q.delete();
      while ((n_acc < n_ops || sb_q.size() != 0) && cyc < budget) begin
         if (rnd) begin
            bus.in_valid  = (n_acc < n_ops) && ($urandom_range(3) != 0);
            bus.in        = rand_finite();
            bus.out_ready = ($urandom_range(3) != 0);
         end else begin
            bus.in_valid  = (n_acc < n_ops);
            bus.in        = tbl[(n_acc < n_ops) ? n_acc : 0].in;
            bus.out_ready = 1'b1;
         end
         @(negedge clk);
         if (bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL stream_extra: got %h, expected no result", bus.out);
            end else begin
               exp_v = sb_q.pop_front();
               chk(rnd ? "random" : "table", {bus.out, bus.out_flags}, exp_v);
            end
            if (first_con < 0) first_con = cyc;
            last_con = cyc;
         end
         if (bus.in_valid && bus.in_ready) begin
            sb_q.push_back(rnd ? model(bus.in) : {tbl[n_acc].out, tbl[n_acc].flags});
            n_acc++;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      bus.in_valid = 1'b0;
      if (cyc >= budget) begin
         n_vec++; n_err++;
         $display("FAIL stream_timeout: got %0d cycles, expected under %0d", cyc, budget);
      end
      if (!rnd) chk("table_no_bubbles", 72'(last_con - first_con), 72'(n_ops - 1));
   endtask

   initial begin
      int n_acc, stale, con_cyc[2], n_con;
      logic [64:0] got[2];

      n_vec = 0; n_err = 0;
      tbl[0]  = '{33'h0_8000_0000, 65'h0_8000_0000_0000_0000, 5'h00}; // 1.0
      tbl[1]  = '{33'h1_8040_0000, 65'h1_8008_0000_0000_0000, 5'h00}; // -1.5
      tbl[2]  = '{33'h0_2000_0001, 65'h0_7400_0000_2000_0000, 5'h00}; // smallest finite exp
      tbl[3]  = '{33'h0_BFFF_FFFF, 65'h0_87FF_FFFF_E000_0000, 5'h00}; // largest finite exp
      tbl[4]  = '{33'h0_E000_0001, 65'h0_E008_0000_2000_0000, 5'h10}; // signaling NaN
      tbl[5]  = '{33'h1_E040_0000, 65'h1_E008_0000_0000_0000, 5'h00}; // quiet NaN
      tbl[6]  = '{33'h1_0000_0000, 65'h1_0000_0000_0000_0000, 5'h00}; // -0
      tbl[7]  = '{33'h0_C000_0000, 65'h0_C000_0000_0000_0000, 5'h00}; // +inf
      tbl[8]  = '{33'h0_1F92_3456, 65'h0_0000_0000_0000_0000, 5'h00}; // zero, junk payload
      tbl[9]  = '{33'h1_D2FF_FFFF, 65'h1_C000_0000_0000_0000, 5'h00}; // -inf, junk payload
      tbl[10] = '{33'h0_FFBF_FFFF, 65'h0_E00F_FFFF_E000_0000, 5'h10}; // signaling NaN, full payload

      reset = 1'b1;
      bus.in_valid = 1'b0; bus.in = '0; bus.out_ready = 1'b0; bus.clear_flags = 1'b0;
      tick(); tick();
      chk("in_ready_in_reset", 72'(bus.in_ready), 72'(0));
      reset = 1'b0;
      tick();
      chk("reset_out_valid", 72'(bus.out_valid), 72'(0));
      chk("reset_out", {bus.out, bus.out_flags}, 72'(0));
      chk("reset_accrued", 72'(bus.accrued_flags), 72'(0));
      chk("reset_in_ready", 72'(bus.in_ready), 72'(1));

      // Two-cycle latency for 1.0
      bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in = tbl[0].in;
      tick();
      bus.in_valid = 1'b0;
      chk("latency_early", 72'(bus.out_valid), 72'(0));
      tick();
      chk("latency_valid", 72'(bus.out_valid), 72'(1));
      chk("latency_value", {bus.out, bus.out_flags}, {tbl[0].out, tbl[0].flags});
      tick();

      stream(1'b0, NV, 100);
      chk("accrued_after_table", 72'(bus.accrued_flags), 72'(5'h10));

      // Backpressure: five offered operands, only two fit
      bus.out_ready = 1'b0; n_acc = 0;
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = 1'b1; bus.in = tbl[i].in;
         @(negedge clk);
         if (bus.in_valid && bus.in_ready) n_acc++;
         tick();
      end
      bus.in_valid = 1'b0;
      #1;
      chk("bp_accepted", 72'(n_acc), 72'(2));
      chk("bp_in_ready", 72'(bus.in_ready), 72'(0));
      chk("bp_hold", {bus.out, bus.out_flags, 1'b0, bus.out_valid}, {tbl[0].out, tbl[0].flags, 2'b01});
      bus.out_ready = 1'b1; n_con = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (bus.out_valid && n_con < 2) begin
            got[n_con] = bus.out; con_cyc[n_con] = c; n_con++;
         end
         tick();
      end
      chk("bp_count", 72'(n_con), 72'(2));
      chk("bp_first", 72'(got[0]), 72'(tbl[0].out));
      chk("bp_second", 72'(got[1]), 72'(tbl[1].out));
      chk("bp_back_to_back", 72'(con_cyc[1] - con_cyc[0]), 72'(1));

      // Clear alone, then clear colliding with a signaling-NaN consume
      bus.clear_flags = 1'b1;
      tick();
      bus.clear_flags = 1'b0;
      chk("clear_alone", 72'(bus.accrued_flags), 72'(0));
      bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in = tbl[4].in;
      tick();
      bus.in_valid = 1'b0;
      tick();
      chk("snan_presented", {bus.out, bus.out_flags, 1'b0, bus.out_valid}, {tbl[4].out, tbl[4].flags, 2'b01});
      chk("accrued_before_consume", 72'(bus.accrued_flags), 72'(0));
      bus.out_ready = 1'b1; bus.clear_flags = 1'b1;
      tick();
      bus.clear_flags = 1'b0;
      chk("clear_vs_set", 72'(bus.accrued_flags), 72'(5'h10));

      // Mid-stream reset with both stages full
      bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in = tbl[0].in;
      tick();
      bus.in = tbl[1].in;
      tick();
      bus.in_valid = 1'b0;
      #1;
      chk("full_in_ready", 72'(bus.in_ready), 72'(0));
      reset = 1'b1;
      tick();
      chk("midreset_out_valid", 72'(bus.out_valid), 72'(0));
      chk("midreset_in_ready", 72'(bus.in_ready), 72'(0));
      reset = 1'b0; bus.out_ready = 1'b1; stale = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (bus.out_valid) stale++;
         tick();
      end
      chk("midreset_no_stale", 72'(stale), 72'(0));
      chk("midreset_accrued", 72'(bus.accrued_flags), 72'(0));

      stream(1'b1, NR, 40000);
      chk("accrued_after_random", 72'(bus.accrued_flags), 72'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
